// File: rtl/quilogramas_para_gramas.sv
// quilogramas_para_gramas: rebuilds a gram value from integer kilograms plus a
// three-digit gram remainder. It multiplies by 1000 with shift-add over 10 cycles,
// then adds the remainder and optionally the scale tare.
// Optional feature macro: TARA_EN (adds TARA_G grams back in the final sum).
module quilogramas_para_gramas #(
    parameter int unsigned LARGURA = 14,
    parameter int unsigned TARA_G  = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] kg_inteiro,
    input  logic [LARGURA-1:0] kg_fracao,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [LARGURA-1:0] peso_gramas,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               erro_fracao,
    output logic               erro_overflow
);

`ifdef TARA_EN
    localparam bit TaraOn = 1'b1;
`else
    localparam bit TaraOn = 1'b0;
`endif

    localparam logic [23:0]        Tara    = TaraOn ? 24'(TARA_G) : 24'd0;
    // 1000 = 10'b1111101000, padded so any 4-bit counter value indexes safely.
    localparam logic [15:0]        MultK   = 16'h03E8;
    localparam logic [23:0]        MaxVal  = 24'((1 << LARGURA) - 1);
    localparam logic [LARGURA-1:0] FracMax = LARGURA'(999);

    typedef enum logic [1:0] {StIdle, StMult, StAdd, StDone} state_e;

    state_e             state_q, state_d;
    logic [23:0]        mcand_q, mcand_d;
    logic [LARGURA-1:0] frac_q, frac_d;
    logic [23:0]        acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [LARGURA-1:0] peso_q, peso_d;
    logic               out_valid_q, out_valid_d;
    logic               erro_fracao_q, erro_fracao_d;
    logic               erro_overflow_q, erro_overflow_d;
    logic [23:0]        sum;

    // Final sum; 24 bits is wide enough that nothing wraps before the overflow compare.
    always_comb begin
        sum = acc_q + 24'(frac_q) + Tara;
    end

    // Next-state logic for the handshake FSM and the shift-add datapath.
    always_comb begin
        state_d         = state_q;
        mcand_d         = mcand_q;
        frac_d          = frac_q;
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        peso_d          = peso_q;
        out_valid_d     = out_valid_q;
        erro_fracao_d   = erro_fracao_q;
        erro_overflow_d = erro_overflow_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d = 24'(kg_inteiro);
                    frac_d  = kg_fracao;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StMult;
                end
            end
            StMult: begin
                if (MultK[cnt_q]) begin
                    acc_d = acc_q + (mcand_q << cnt_q);
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    state_d = StAdd;
                end
            end
            StAdd: begin
                state_d     = StDone;
                out_valid_d = 1'b1;
                // An illegal remainder takes precedence over overflow.
                if (frac_q > FracMax) begin
                    erro_fracao_d   = 1'b1;
                    erro_overflow_d = 1'b0;
                    peso_d          = '0;
                end else if (sum > MaxVal) begin
                    erro_fracao_d   = 1'b0;
                    erro_overflow_d = 1'b1;
                    peso_d          = '1;
                end else begin
                    erro_fracao_d   = 1'b0;
                    erro_overflow_d = 1'b0;
                    peso_d          = sum[LARGURA-1:0];
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d     = 1'b0;
                    erro_fracao_d   = 1'b0;
                    erro_overflow_d = 1'b0;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            mcand_q         <= '0;
            frac_q          <= '0;
            acc_q           <= '0;
            cnt_q           <= '0;
            peso_q          <= '0;
            out_valid_q     <= 1'b0;
            erro_fracao_q   <= 1'b0;
            erro_overflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            mcand_q         <= mcand_d;
            frac_q          <= frac_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            peso_q          <= peso_d;
            out_valid_q     <= out_valid_d;
            erro_fracao_q   <= erro_fracao_d;
            erro_overflow_q <= erro_overflow_d;
        end
    end

    // Output drive; in_ready is a pure decode of the idle state.
    always_comb begin
        in_ready      = (state_q == StIdle);
        peso_gramas   = peso_q;
        out_valid     = out_valid_q;
        erro_fracao   = erro_fracao_q;
        erro_overflow = erro_overflow_q;
    end

endmodule

// File: tb/tb_quilogramas_para_gramas.sv
// Directed bench for quilogramas_para_gramas; follows TARA_EN for the tare term.
module tb_quilogramas_para_gramas;

`ifdef TARA_EN
    localparam int TARE = 40;
`else
    localparam int TARE = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [13:0] kg_inteiro;
    logic [13:0] kg_fracao;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] peso_gramas;
    logic        out_valid;
    logic        out_ready;
    logic        erro_fracao;
    logic        erro_overflow;

    int total;
    int bad;

    quilogramas_para_gramas dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .kg_inteiro    (kg_inteiro),
        .kg_fracao     (kg_fracao),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .peso_gramas   (peso_gramas),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .erro_fracao   (erro_fracao),
        .erro_overflow (erro_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one word, waits for acceptance, returns edges from acceptance to out_valid.
    task automatic send(input int kg, input int fr, output int lat);
        int w;
        kg_inteiro = 14'(kg);
        kg_fracao  = 14'(fr);
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        total++;
        if (peso_gramas !== 14'd0 || erro_fracao !== 1'b0 || erro_overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: peso=%0d ef=%b eo=%b want 0 0 0",
                     peso_gramas, erro_fracao, erro_overflow);
        end
    endtask

    task automatic test_nominal();
        int lat;
        out_ready = 1'b1;
        send(2, 345, lat);
        total++;
        if (lat !== 11) begin
            bad++;
            $display("FAIL nominal_latency: got=%0d want=11", lat);
        end
        total++;
        if (peso_gramas !== 14'(2345 + TARE) || erro_fracao !== 1'b0 || erro_overflow !== 1'b0)
        begin
            bad++;
            $display("FAIL nominal_value: peso=%0d ef=%b eo=%b want %0d 0 0",
                     peso_gramas, erro_fracao, erro_overflow, 2345 + TARE);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL nominal_consume: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_boundary();
        int kgs[4]  = '{16, 16, 20, 16};
        int frs[4]  = '{343, 344, 0, 384};
        int lat;
        int expv;
        int expo;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(kgs[i], frs[i], lat);
            expv = kgs[i] * 1000 + frs[i] + TARE;
            expo = (expv > 16383) ? 1 : 0;
            if (expv > 16383) expv = 16383;
            total++;
            if (peso_gramas !== 14'(expv) || erro_overflow !== 1'(expo) || erro_fracao !== 1'b0
                || lat !== 11) begin
                bad++;
                $display("FAIL boundary_%0d: peso=%0d eo=%b ef=%b lat=%0d want %0d %0d 0 11",
                         i, peso_gramas, erro_overflow, erro_fracao, lat, expv, expo);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fracao();
        int lat;
        out_ready = 1'b1;
        send(1, 1000, lat);
        total++;
        if (erro_fracao !== 1'b1 || peso_gramas !== 14'd0 || erro_overflow !== 1'b0) begin
            bad++;
            $display("FAIL fracao: ef=%b peso=%0d eo=%b want 1 0 0",
                     erro_fracao, peso_gramas, erro_overflow);
        end
        @(posedge clk); #1;
        total++;
        if (erro_fracao !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL fracao_clear: ef=%b out_valid=%b want 0 0", erro_fracao, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int held_bad;
        out_ready = 1'b0;
        send(0, 0, lat);
        held_bad = 0;
        in_valid   = 1'b1;
        kg_inteiro = 14'd5;
        kg_fracao  = 14'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (peso_gramas !== 14'(TARE) || out_valid !== 1'b1 || in_ready !== 1'b0) held_bad++;
        end
        total++;
        if (held_bad !== 0) begin
            bad++;
            $display("FAIL backpressure_hold: bad cycles=%0d want 0 (peso=%0d ov=%b ir=%b)",
                     held_bad, peso_gramas, out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1",
                     out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (peso_gramas !== 14'(5000 + TARE) || lat !== 11 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_next: peso=%0d lat=%0d want %0d 11",
                     peso_gramas, lat, 5000 + TARE);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        out_ready  = 1'b1;
        kg_inteiro = 14'd9;
        kg_fracao  = 14'd9;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_mid_abort: out_valid cycles=%0d want 0", seen);
        end
        send(3, 7, lat);
        total++;
        if (peso_gramas !== 14'(3007 + TARE) || lat !== 11) begin
            bad++;
            $display("FAIL reset_mid_after: peso=%0d lat=%0d want %0d 11",
                     peso_gramas, lat, 3007 + TARE);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int acc_t[2];
        logic [13:0] res[2];
        logic flg[2];
        int nacc;
        int nres;
        logic go;
        out_ready  = 1'b1;
        kg_inteiro = 14'd1;
        kg_fracao  = 14'd0;
        in_valid   = 1'b1;
        nacc = 0;
        nres = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        for (int c = 0; c < 80 && nres < 2; c++) begin
            go = in_valid && in_ready;
            if (out_valid) begin
                res[nres] = peso_gramas;
                flg[nres] = erro_fracao | erro_overflow;
                nres++;
            end
            @(posedge clk); #1;
            if (go && nacc < 2) begin
                acc_t[nacc] = c;
                nacc++;
                if (nacc == 1) begin
                    kg_inteiro = 14'd0;
                    kg_fracao  = 14'd999;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (nacc !== 2 || acc_t[1] - acc_t[0] !== 13) begin
            bad++;
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d want 2 13", nacc, acc_t[1] - acc_t[0]);
        end
        total++;
        if (nres !== 2 || res[0] !== 14'(1000 + TARE) || res[1] !== 14'(999 + TARE)
            || flg[0] !== 1'b0 || flg[1] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_values: n=%0d r0=%0d r1=%0d want 2 %0d %0d",
                     nres, res[0], res[1], 1000 + TARE, 999 + TARE);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        kg_inteiro = '0;
        kg_fracao  = '0;
        test_reset();
        test_nominal();
        test_boundary();
        test_fracao();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
